// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// A start/busy/done handshake launches an add and returns sum, cout and ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ra, rb, rs;
  logic             c, cm;
  logic [CW-1:0]    cnt;

  logic             s_bit, c_nx, last, pre_msb;

  // Full-adder cell on the current LSBs of the operand shifters
  always_comb begin
    s_bit   = ra[0] ^ rb[0] ^ c;
    c_nx    = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
    last    = (state == SHIFT) && (cnt == CW'(WIDTH-1));
    pre_msb = (state == SHIFT) && (cnt == CW'(WIDTH-2));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cm    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SHIFT);
      done  <= last;
      if (state == IDLE) begin
        if (start) begin
          ra  <= a;
          rb  <= b;
          c   <= cin;
          cnt <= '0;
        end
      end else begin
        c   <= c_nx;
        rs  <= {s_bit, rs[WIDTH-1:1]};
        ra  <= {1'b0, ra[WIDTH-1:1]};
        rb  <= {1'b0, rb[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
        // carry into the MSB, kept for the signed-overflow flag
        if (pre_msb) cm <= c_nx;
        if (last) begin
          sum  <= {s_bit, rs[WIDTH-1:1]};
          cout <= c_nx;
          ovf  <= cm ^ c_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corners, handshake cases,
// and randomized adds checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic and the sign rule
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    int unsigned  t;
    logic [W:0]   r;
    logic         v;
    t = int'(x) + int'(y) + int'(ci);
    r = t[W:0];
    v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {v, r};
  endfunction

  // Launch one add; optionally poke start with FF+FF at cycle poke after acceptance.
  task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input int poke);
    logic [W+1:0] e;
    logic [W-1:0] s_cap;
    logic         c_cap, v_cap;
    int           dcyc, ndone, bcnt;
    e = ref_add(ta, tb, tc);
    dcyc = -1; ndone = 0; bcnt = 0;
    s_cap = '0; c_cap = 1'b0; v_cap = 1'b0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    if (busy === 1'b1) bcnt++;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      start = (k == poke);
      if (k == poke) begin a = '1; b = '1; end
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = k; s_cap = sum; c_cap = cout; v_cap = ovf;
        end
      end
    end
    start = 1'b0;
    chk({tag, "/latency"}, dcyc, W);
    chk({tag, "/ndone"}, ndone, 1);
    chk({tag, "/busycyc"}, bcnt, W);
    chk({tag, "/sum"}, s_cap, e[W-1:0]);
    chk({tag, "/cout"}, c_cap, e[W]);
    chk({tag, "/ovf"}, v_cap, e[W+1]);
    chk({tag, "/hold"}, {ovf, cout, sum}, e);
  endtask

  initial begin
    int d1, d2;
    logic [W+1:0] e;
    rst_n = 1'b0; start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/res", {ovf, cout, sum}, 0);
    start = 1'b0; rst_n = 1'b1;

    run_add("zero", 8'h00, 8'h00, 1'b0, -1);
    run_add("7f+01", 8'h7F, 8'h01, 1'b0, -1);
    run_add("ff+01", 8'hFF, 8'h01, 1'b0, -1);
    run_add("80+80", 8'h80, 8'h80, 1'b0, -1);
    run_add("ff+00c", 8'hFF, 8'h00, 1'b1, -1);
    run_add("3c+5ac", 8'h3C, 8'h5A, 1'b1, -1);
    chk("3c+5ac/lit", {ovf, cout, sum}, {1'b1, 1'b0, 8'h97});
    run_add("busystart", 8'h12, 8'h34, 1'b0, 3);
    chk("busystart/lit", sum, 8'h46);

    // reset mid-operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst/busy", busy, 0);
    chk("midrst/done", done, 0);
    chk("midrst/res", {ovf, cout, sum}, 0);
    rst_n = 1'b1;
    d1 = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) d1++;
    end
    chk("midrst/nodone", d1, 0);
    run_add("01+01", 8'h01, 8'h01, 1'b0, -1);
    chk("01+01/lit", sum, 8'h02);

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hF0; b = 8'h20;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 2 * W + 4; k++) begin
      @(posedge clk); #1;
      if (k == W + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = k;
          chk("b2b/sum1", {cout, sum}, {1'b0, 8'h30});
        end else if (d2 < 0) begin
          d2 = k;
          chk("b2b/sum2", {cout, sum}, {1'b1, 8'h10});
        end
      end
    end
    chk("b2b/d1", d1, W);
    chk("b2b/d2", d2, 2 * W + 1);

    // randomized adds against the reference model
    for (int n = 0; n < 1200; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_add("rnd", ra, rb, rc, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
